// File: rtl/rssb_core_if.sv
// Memory bus between the RSSB core and its mem_data unified ROM/RAM.
// The core drives address, write data and write enable. The memory
// returns combinational read data for the current address.
interface rssb_core_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_write;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_write,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/rssb_core.sv
// RSSB (reverse-subtract, skip-if-borrow) one-instruction machine.
// Each instruction takes three cycles: FETCH the operand address from the
// program, READ the addressed word, then EXEC acc <= mem[a] - acc with a
// write-back to RAM and a PC skip on borrow. The upper half of the address
// space is ROM and is never written. Bus outputs depend only on state and
// registers, so the combinational read path of mem_data cannot form a loop.
module rssb_core #(
    parameter int WIDTH     = 8,
    parameter int HALT_ADDR = 0,
    parameter int OUT_ADDR  = 1
) (
    input  logic             clk,
    input  logic             rst,
    rssb_core_if.master      mem,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] pc,
    output logic             halted,
    output logic [WIDTH-1:0] out_data,
    output logic             out_strobe
);

    localparam logic [WIDTH-1:0] PC_RESET = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] HALT_W   = WIDTH'(HALT_ADDR);
    localparam logic [WIDTH-1:0] OUT_W    = WIDTH'(OUT_ADDR);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic [1:0] {
        FETCH,
        READ,
        EXEC,
        HALT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] ar;
    logic [WIDTH-1:0] mdr;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ram_target;

    assign diff       = mdr - acc;
    assign borrow     = (mdr < acc);
    assign ram_target = ~ar[WIDTH-1];
    assign halted     = (state == HALT);

    // State register; reset drops straight to FETCH so any pending write
    // enable is removed without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and bus drive for the current state.
    always_comb begin
        state_next    = state;
        mem.mem_addr  = pc;
        mem.mem_wdata = diff;
        mem.mem_write = 1'b0;
        case (state)
            FETCH: begin
                if (mem.mem_rdata == HALT_W) begin
                    state_next = HALT;
                end else begin
                    state_next = READ;
                end
            end
            READ: begin
                mem.mem_addr = ar;
                state_next   = EXEC;
            end
            EXEC: begin
                mem.mem_addr  = ar;
                mem.mem_write = ram_target;
                state_next    = FETCH;
            end
            default: begin
                state_next = HALT;
            end
        endcase
    end

    // Architectural registers: operand latch, data latch, accumulator,
    // program counter and the memory-mapped output port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= PC_RESET;
            acc        <= '0;
            ar         <= '0;
            mdr        <= '0;
            out_data   <= '0;
            out_strobe <= 1'b0;
        end else begin
            out_strobe <= 1'b0;
            case (state)
                FETCH: begin
                    if (mem.mem_rdata != HALT_W) begin
                        ar <= mem.mem_rdata;
                    end
                end
                READ: begin
                    mdr <= mem.mem_rdata;
                end
                EXEC: begin
                    acc <= diff;
                    pc  <= pc + ONE + WIDTH'(borrow);
                    if (ram_target && (ar == OUT_W)) begin
                        out_data   <= diff;
                        out_strobe <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rssb_core.sv
// Bench for rssb_core: a 256-word memory stands in for mem_data, and an
// instruction-level model of the RSSB machine predicts every bus and
// register output cycle by cycle. Directed programs pin the model with
// hand-computed results; randomized programs exercise it broadly.
module tb_rssb_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] acc;
    logic [7:0] pc;
    logic       halted;
    logic [7:0] out_data;
    logic       out_strobe;

    rssb_core_if #(.WIDTH(8)) bus ();

    rssb_core #(.WIDTH(8), .HALT_ADDR(0), .OUT_ADDR(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (bus),
        .acc        (acc),
        .pc         (pc),
        .halted     (halted),
        .out_data   (out_data),
        .out_strobe (out_strobe)
    );

    always #5 clk = ~clk;

    // Memory environment: image loaded while 'load' is high, otherwise
    // commits core writes on the rising edge; read is combinational.
    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       load = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (bus.mem_write) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural state of the machine plus the cycle
    // within the current instruction (each instruction spans three cycles).
    logic [7:0] m_pc, m_acc, m_out, m_op;
    logic       m_strobe, m_halt;
    int         m_phase;
    logic [7:0] m_mem [256];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc     <= 8'h80;
            m_acc    <= 8'h00;
            m_out    <= 8'h00;
            m_op     <= 8'h00;
            m_strobe <= 1'b0;
            m_halt   <= 1'b0;
            m_phase  <= 0;
            if (load) begin
                for (int i = 0; i < 256; i++) m_mem[i] <= img[i];
            end
        end else begin
            m_strobe <= 1'b0;
            if (!m_halt) begin
                if (m_phase == 0) begin
                    if (m_mem[m_pc] == 8'h00) begin
                        m_halt <= 1'b1;
                    end else begin
                        m_op    <= m_mem[m_pc];
                        m_phase <= 1;
                    end
                end else if (m_phase == 1) begin
                    m_phase <= 2;
                end else begin
                    m_phase <= 0;
                    m_acc   <= m_mem[m_op] - m_acc;
                    m_pc    <= m_pc + ((m_mem[m_op] < m_acc) ? 8'd2 : 8'd1);
                    if (m_op < 8'h80) begin
                        m_mem[m_op] <= m_mem[m_op] - m_acc;
                        if (m_op == 8'h01) begin
                            m_out    <= m_mem[m_op] - m_acc;
                            m_strobe <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            logic [7:0] e_addr;
            logic       e_we;
            e_addr = (m_halt || m_phase == 0) ? m_pc : m_op;
            e_we   = !m_halt && (m_phase == 2) && (m_op < 8'h80);
            chk("mem_addr", bus.mem_addr, e_addr);
            chk("mem_write", {7'd0, bus.mem_write}, {7'd0, e_we});
            chk("pc", pc, m_pc);
            chk("acc", acc, m_acc);
            chk("halted", {7'd0, halted}, {7'd0, m_halt});
            chk("out_data", out_data, m_out);
            chk("out_strobe", {7'd0, out_strobe}, {7'd0, m_strobe});
            if (e_we) chk("mem_wdata", bus.mem_wdata, m_mem[m_op] - m_acc);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        load = 1'b1;
        rst  = 1'b0;
        #1 started = 1'b1;
        repeat (2) @(negedge clk);
        load = 1'b0;
        rst  = 1'b1;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
    endtask

    initial begin
        int n_strobe;
        bit seen;
        logic [7:0] r;

        // Directed program: no-borrow, borrow/skip, ROM target, output, halt.
        clear_img();
        img[8'h80] = 8'h10; img[8'h81] = 8'h11; img[8'h83] = 8'hA0;
        img[8'h85] = 8'h01; img[8'h87] = 8'h00; img[8'hA0] = 8'h40;
        img[8'h10] = 8'h05; img[8'h11] = 8'h03; img[8'h01] = 8'h09;
        do_reset();
        #1;
        chk("rst_pc", pc, 8'h80);
        chk("rst_acc", acc, 8'h00);
        chk("rst_addr", bus.mem_addr, 8'h80);
        chk("rst_write", {7'd0, bus.mem_write}, 8'h00);
        chk("rst_halted", {7'd0, halted}, 8'h00);
        chk("rst_strobe", {7'd0, out_strobe}, 8'h00);
        repeat (3) @(negedge clk);
        chk("i1_pc", pc, 8'h81);
        chk("i1_acc", acc, 8'h05);
        chk("i1_ram10", mem[8'h10], 8'h05);
        n_strobe = 0;
        for (int i = 0; i < 40 && !halted; i++) begin
            @(negedge clk);
            if (out_strobe) n_strobe++;
        end
        chk("a_halted", {7'd0, halted}, 8'h01);
        chk("a_pc", pc, 8'h87);
        chk("a_acc", acc, 8'hC7);
        chk("a_out", out_data, 8'hC7);
        chk("a_ram1", mem[8'h01], 8'hC7);
        chk("a_ram11", mem[8'h11], 8'hFE);
        chk("a_romA0", mem[8'hA0], 8'h40);
        chk("a_strobes", 8'(n_strobe), 8'h01);
        repeat (10) @(negedge clk);
        chk("a_pc_frozen", pc, 8'h87);

        // Asynchronous reset while the EXEC write is pending.
        clear_img();
        img[8'h80] = 8'h20; img[8'h20] = 8'h33;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_write) seen = 1'b1;
        end
        chk("b_write_seen", {7'd0, seen}, 8'h01);
        #3 rst = 1'b0;
        #1;
        chk("b_async_write", {7'd0, bus.mem_write}, 8'h00);
        chk("b_async_pc", pc, 8'h80);
        @(posedge clk);
        #1 chk("b_ram20", mem[8'h20], 8'h33);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // PC wrap from 0xFF into RAM; RAM[0] then halts at pc 0x00.
        clear_img();
        for (int i = 8'h80; i < 256; i++) img[i] = 8'hFE;
        do_reset();
        for (int i = 0; i < 500 && !halted; i++) @(negedge clk);
        chk("c_halted", {7'd0, halted}, 8'h01);
        chk("c_pc", pc, 8'h00);
        chk("c_acc", acc, 8'h00);

        // Randomized programs, some with a reset injected mid-run.
        for (int run = 0; run < 6; run++) begin
            for (int i = 0; i < 128; i++) img[i] = 8'($urandom);
            for (int i = 128; i < 256; i++) begin
                case ($urandom_range(0, 9))
                    0, 1:    r = 8'h01;
                    2, 3, 4, 5, 6: r = 8'($urandom_range(1, 127));
                    7, 8:    r = 8'($urandom_range(128, 255));
                    default: r = 8'($urandom);
                endcase
                img[i] = r;
            end
            do_reset();
            repeat ($urandom_range(20, 200)) @(negedge clk);
            if (run % 2 == 1) begin
                #3 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
            repeat (300) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
